// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame constants and the baud divider.
// Used by the transmitter now and intended for the receiver as well.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  // Clocks per bit, truncated toward zero.
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..DIV-1 while enabled and flags the last clock of each bit.
// Held at zero whenever en is low so every bit starts on a clean period.
module uart_baud_tick #(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic arst,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Period counter, wrapping at DIV-1
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// 8N1 UART transmitter that sends a DEPTH-byte word back-to-back, byte 0 first, LSB first.
// All outputs, including tx, come straight from flops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int boadrate = 115200,
  parameter int DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [DEPTH-1:0][7:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV = baud_div(CLK_FREQ, boadrate);
  localparam int W   = DEPTH * DATA_BITS;
  localparam int BW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(DEPTH - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  uart_state_e   state, state_nx;
  logic [W-1:0]  shreg, shreg_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [BW-1:0] byte_idx, byte_idx_nx;
  logic          tx_nx, ready_nx, busy_nx, done_nx;
  logic          tick;

  uart_baud_tick #(.DIV(DIV)) u_baud (
    .clk  (clk),
    .arst (arst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // State, shift register, counters and registered outputs
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= 3'd0;
      byte_idx <= '0;
      tx       <= 1'b1;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bit_idx  <= bit_idx_nx;
      byte_idx <= byte_idx_nx;
      tx       <= tx_nx;
      ready    <= ready_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Next-state logic; tx_nx is the line level for the coming cycle.
  // The shift register moves one bit per data tick, so shreg[0] is always the bit on the line.
  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_idx_nx  = bit_idx;
    byte_idx_nx = byte_idx;
    tx_nx       = tx;
    ready_nx    = ready;
    busy_nx     = busy;
    done_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (valid && ready) begin
          state_nx    = START;
          shreg_nx    = data;
          bit_idx_nx  = 3'd0;
          byte_idx_nx = '0;
          tx_nx       = 1'b0;
          ready_nx    = 1'b0;
          busy_nx     = 1'b1;
        end else begin
          tx_nx = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_nx   = DATA;
          bit_idx_nx = 3'd0;
          tx_nx      = shreg[0];
        end else begin
          tx_nx = 1'b0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_nx = {1'b0, shreg[W-1:1]};
          if (bit_idx == LAST_BIT) begin
            state_nx = STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_idx_nx = bit_idx + 3'd1;
            tx_nx      = shreg[1];
          end
        end else begin
          tx_nx = shreg[0];
        end
      end
      STOP: begin
        if (tick) begin
          if (byte_idx != LAST_BYTE) begin
            state_nx    = START;
            byte_idx_nx = byte_idx + BW'(1);
            tx_nx       = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            ready_nx = 1'b1;
          end
        end else begin
          tx_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
        ready_nx = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench: accepted words are queued with their accept cycle; a monitor checks the
// exact line waveform, done timing and a loopback receiver's decoded word on every done pulse.
module tb_uart_tx_frame;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int NBITS    = DEPTH * 10;
  localparam int N        = NBITS * DIV;

  logic clk = 1'b0;
  logic arst = 1'b1;
  logic [DEPTH-1:0][7:0] data;
  logic valid;
  logic ready, tx, busy, done;
  logic [0:0][7:0] data1;
  logic valid1;
  logic ready1, tx1, busy1, done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int idle_bad = 0;

  typedef struct packed {
    logic [31:0] word;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rx_q[$];
  logic        rxerr_q[$];
  logic        tx_hist[0:65535];

  uart_tx_frame #(.CLK_FREQ(CLK_FREQ), .boadrate(BAUD), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .arst(arst), .data(data), .valid(valid),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  uart_tx_frame #(.CLK_FREQ(CLK_FREQ), .boadrate(BAUD), .DEPTH(1)) u_dut1 (
    .clk(clk), .arst(arst), .data(data1), .valid(valid1),
    .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Line level k clocks after the accepting edge, from the 8N1 frame rules.
  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int j, b, p;
    j = k / DIV;
    b = j / 10;
    p = j % 10;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[b*8 + p - 1];
  endfunction

  // Loopback receiver: detects the start edge and samples each bit at mid-period.
  initial begin
    logic on, prev, ferr;
    logic [31:0] w;
    int rc, j, b, p;
    on = 1'b0; prev = 1'b1; ferr = 1'b0; w = '0; rc = 0;
    forever begin
      @(negedge clk);
      if (arst) begin
        on = 1'b0; prev = 1'b1;
      end else begin
        if (!on && prev && !tx) begin
          on = 1'b1; rc = 0; ferr = 1'b0; w = '0;
        end
        if (on) begin
          if (rc % DIV == DIV / 2) begin
            j = rc / DIV; b = j / 10; p = j % 10;
            if (p == 0) begin
              if (tx !== 1'b0) ferr = 1'b1;
            end else if (p == 9) begin
              if (tx !== 1'b1) ferr = 1'b1;
            end else begin
              w[b*8 + p - 1] = tx;
            end
            if (j == NBITS - 1) begin
              rx_q.push_back(w);
              rxerr_q.push_back(ferr);
              on = 1'b0;
            end
          end
          rc++;
        end
        prev = tx;
      end
    end
  end

  // Monitor: records the line and scores each word when done is presented
  initial begin
    exp_t e;
    int mism, first;
    logic [31:0] rw;
    logic rerr;
    forever begin
      @(negedge clk);
      tx_hist[cyc] = tx;
      if (!arst && exp_q.size() == 0 && tx !== 1'b1) idle_bad++;
      if (!arst && done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.acc + N));
          mism = 0; first = -1;
          for (int k = 0; k < N; k++) begin
            if (tx_hist[e.acc + k] !== exp_bit(e.word, k)) begin
              mism++;
              if (first < 0) first = k;
            end
          end
          if (mism != 0) $display("first line error at clock %0d of word %08h", first, e.word);
          check("line_bits", 32'(mism), 32'd0);
          if (rx_q.size() == 0) begin
            check("rx_word_present", 32'd0, 32'd1);
          end else begin
            rw = rx_q.pop_front();
            rerr = rxerr_q.pop_front();
            check("rx_word", rw, e.word);
            check("rx_framing", 32'(rerr), 32'd0);
          end
        end
      end
    end
  end

  task automatic offer(input logic [31:0] w, output int acc);
    exp_t e;
    bit ok;
    ok = 1'b0; acc = -1;
    data = w; valid = 1'b1;
    for (int t = 0; t < 3 * N && !ok; t++) begin
      if (ready === 1'b1) begin
        e.word = w; e.acc = cyc + 1;
        exp_q.push_back(e);
        acc = e.acc; ok = 1'b1;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: ready stayed 0 for %0d cycles, expected 1", 3 * N);
    end
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2 * N) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: %0d words outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a1, a2, mism;
    logic [31:0] w;
    valid = 1'b1; data = '1; valid1 = 1'b0; data1 = '0;

    // reset held with valid high
    repeat (3) begin
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
    end
    valid = 1'b0;
    arst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_tx", 32'(tx), 32'd1);
    check("post_rst_ready", 32'(ready), 32'd1);

    // single word
    offer(32'hF0F0_F055, a);
    valid = 1'b0;
    check("accept_ready", 32'(ready), 32'd0);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_tx", 32'(tx), 32'd0);
    wait_drained();
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    // valid while busy is ignored
    offer($urandom, a);
    valid = 1'b0;
    repeat (N / 2) @(negedge clk);
    data = 32'hFFFF_FFFF; valid = 1'b1;
    check("busy_ready", 32'(ready), 32'd0);
    @(negedge clk);
    valid = 1'b0;
    wait_drained();
    repeat (3 * DIV) @(negedge clk);
    check("no_second_busy", 32'(busy), 32'd0);

    // back-to-back with valid held
    offer(32'h0102_0304, a1);
    offer(32'hA5A5_A5A5, a2);
    valid = 1'b0;
    check("b2b_gap", 32'(a2 - a1), 32'(N + 1));
    wait_drained();

    // random words with random gaps
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      offer($urandom, a);
      valid = 1'b0;
    end
    wait_drained();

    // reset during byte 2, bit 3
    offer($urandom, a);
    valid = 1'b0;
    while (cyc < a + 24 * DIV + 3) @(negedge clk);
    arst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    rx_q.delete(); rxerr_q.delete();
    repeat (N) @(negedge clk);
    w = $urandom;
    offer(w, a);
    valid = 1'b0;
    wait_drained();

    // single-byte instance, DIV=10
    @(negedge clk);
    data1 = 8'hC3; valid1 = 1'b1;
    check("d1_ready", 32'(ready1), 32'd1);
    @(negedge clk);
    valid1 = 1'b0;
    mism = 0;
    for (int k = 0; k < 10 * DIV; k++) begin
      if (tx1 !== exp_bit(32'h0000_00C3, k) || done1 !== 1'b0) mism++;
      @(negedge clk);
    end
    check("d1_frame", 32'(mism), 32'd0);
    check("d1_done", 32'(done1), 32'd1);
    @(negedge clk);
    check("d1_done_pulse", 32'(done1), 32'd0);

    check("idle_line", 32'(idle_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
